// File: rtl/mem_wb_pipe_pkg.sv
// Shared defines for the MEM/WB stage plus the package that names the buffer states.
// Macros live here so any file compiled after this one sees the same encodings.
`ifndef MEM_WB_PIPE_DEFINES
`define MEM_WB_PIPE_DEFINES
`define RstEnable    1'b1
`define RstDisable   1'b0
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define NOPRegAddr   5'b00000
`define ZeroWord     32'h00000000
`define PipeEmpty    2'd0
`define PipeOne      2'd1
`define PipeTwo      2'd2
`endif

package mem_wb_pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = `PipeEmpty,
        PIPE_ONE   = `PipeOne,
        PIPE_TWO   = `PipeTwo
    } pipe_state_e;

    // Number of buffered entries held in a given state.
    function automatic logic [1:0] occ_of(input pipe_state_e s);
        case (s)
            PIPE_ONE: occ_of = 2'd1;
            PIPE_TWO: occ_of = 2'd2;
            default:  occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid.sv
// Generic 2-entry in-order valid/ready buffer: a main (head) register plus a skid register.
// in_ready and out_valid decode only the state register, so there is no ready-to-ready path.
import mem_wb_pipe_pkg::*;

module pipe_skid #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [W-1:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [W-1:0] out_data,
    output pipe_state_e state
);

    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         acc;
    logic         pop;

    // valid/ready: a transfer happens on an edge where both are 1; valid never waits on ready.
    assign in_ready  = (state != PIPE_TWO);
    assign out_valid = (state != PIPE_EMPTY);
    assign out_data  = main_q;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            state  <= PIPE_EMPTY;
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else if (flush) begin
            state <= PIPE_EMPTY;
        end else begin
            case (state)
                PIPE_EMPTY: begin
                    if (acc) begin
                        main_q <= in_data;
                        state  <= PIPE_ONE;
                    end
                end
                PIPE_ONE: begin
                    if (acc && !pop) begin
                        skid_q <= in_data;
                        state  <= PIPE_TWO;
                    end else if (pop && !acc) begin
                        state <= PIPE_EMPTY;
                    end else if (acc && pop) begin
                        main_q <= in_data;
                    end
                end
                PIPE_TWO: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= PIPE_ONE;
                    end
                end
                default: state <= PIPE_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a 2-deep skid buffer; write enables are only ever
// presented from a valid head slot.
import mem_wb_pipe_pkg::*;

module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic [1:0]        occ
);

    localparam int PW = REG_AW + 2 + 3 * DATA_W;

    // Payload order: {wd, wreg, wdata, whilo, hi, lo}.
    localparam logic [PW-1:0] RST_PAYLOAD = {
        REG_AW'(`NOPRegAddr), `WriteDisable, DATA_W'(`ZeroWord),
        `WriteDisable, DATA_W'(`ZeroWord), DATA_W'(`ZeroWord)
    };

    logic [PW-1:0] in_payload;
    logic [PW-1:0] head_payload;
    logic          head_wreg;
    logic          head_whilo;
    pipe_state_e   state;

    assign in_payload = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo};

    pipe_skid #(
        .W       (PW),
        .RST_VAL (RST_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (mem_valid),
        .in_ready  (mem_ready),
        .in_data   (in_payload),
        .out_valid (wb_valid),
        .out_ready (wb_ready),
        .out_data  (head_payload),
        .state     (state)
    );

    assign {wb_wd, head_wreg, wb_wdata, head_whilo, wb_hi, wb_lo} = head_payload;
    assign wb_wreg  = head_wreg && wb_valid;
    assign wb_whilo = head_whilo && wb_valid;
    assign occ      = occ_of(state);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: a 32/5 and a 64/6 instance share all handshake controls;
// a queue model of the in-order buffer predicts occupancy and the head entry every cycle.
module tb_mem_wb_pipe;

    typedef struct packed {
        logic [4:0]  wd_a;
        logic        wreg;
        logic        whilo;
        logic [31:0] wdata_a;
        logic [31:0] hi_a;
        logic [31:0] lo_a;
        logic [5:0]  wd_b;
        logic [63:0] wdata_b;
        logic [63:0] hi_b;
        logic [63:0] lo_b;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic flush = 1'b0;
    logic mem_valid = 1'b0;
    logic wb_ready = 1'b0;
    ent_t cur = '0;

    logic        mem_ready_a, wb_valid_a, wb_wreg_a, wb_whilo_a;
    logic [4:0]  wb_wd_a;
    logic [31:0] wb_wdata_a, wb_hi_a, wb_lo_a;
    logic [1:0]  occ_a;
    logic        mem_ready_b, wb_valid_b, wb_wreg_b, wb_whilo_b;
    logic [5:0]  wb_wd_b;
    logic [63:0] wb_wdata_b, wb_hi_b, wb_lo_b;
    logic [1:0]  occ_b;

    mem_wb_pipe #(.DATA_W(32), .REG_AW(5)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready_a),
        .mem_wd(cur.wd_a), .mem_wreg(cur.wreg), .mem_wdata(cur.wdata_a),
        .mem_whilo(cur.whilo), .mem_hi(cur.hi_a), .mem_lo(cur.lo_a),
        .wb_valid(wb_valid_a), .wb_ready(wb_ready),
        .wb_wd(wb_wd_a), .wb_wreg(wb_wreg_a), .wb_wdata(wb_wdata_a),
        .wb_whilo(wb_whilo_a), .wb_hi(wb_hi_a), .wb_lo(wb_lo_a), .occ(occ_a)
    );

    mem_wb_pipe #(.DATA_W(64), .REG_AW(6)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready_b),
        .mem_wd(cur.wd_b), .mem_wreg(cur.wreg), .mem_wdata(cur.wdata_b),
        .mem_whilo(cur.whilo), .mem_hi(cur.hi_b), .mem_lo(cur.lo_b),
        .wb_valid(wb_valid_b), .wb_ready(wb_ready),
        .wb_wd(wb_wd_b), .wb_wreg(wb_wreg_b), .wb_wdata(wb_wdata_b),
        .wb_whilo(wb_whilo_b), .wb_hi(wb_hi_b), .wb_lo(wb_lo_b), .occ(occ_b)
    );

    // Scoreboard state: exp_q holds the entries the DUT should be buffering, head first.
    ent_t exp_q[$];
    logic pushed_now = 1'b0;
    logic armed = 1'b0;
    logic last_rst = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   exp_occ;
    ent_t h;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        ent_t e;
        e.wd_a    = wd;
        e.wreg    = wreg;
        e.whilo   = whilo;
        e.wdata_a = wdata;
        e.hi_a    = hi;
        e.lo_a    = lo;
        e.wd_b    = {1'b1, wd};
        e.wdata_b = {~wdata, wdata};
        e.hi_b    = {~hi, hi};
        e.lo_b    = {~lo, lo};
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.wd_a    = 5'($urandom);
        e.wreg    = 1'($urandom);
        e.whilo   = 1'($urandom);
        e.wdata_a = $urandom;
        e.hi_a    = $urandom;
        e.lo_a    = $urandom;
        e.wd_b    = 6'($urandom);
        e.wdata_b = {$urandom, $urandom};
        e.hi_b    = {$urandom, $urandom};
        e.lo_b    = {$urandom, $urandom};
        return e;
    endfunction

    // Driver: one cycle of stimulus, applied 2 time units after the rising edge.
    task automatic step(input logic rs, input logic fl, input logic v, input logic rdy, input ent_t e);
        @(posedge clk);
        #2;
        rst       = rs;
        flush     = fl;
        mem_valid = v;
        wb_ready  = rdy;
        cur       = e;
        if (v && !fl && !rs && exp_q.size() < 2) begin
            exp_q.push_back(e);
            pushed_now = 1'b1;
        end
    endtask

    // Monitor: compares the DUT state left by the last edge, then retires what the next edge removes.
    always @(negedge clk) begin
        exp_occ = exp_q.size() - (pushed_now ? 1 : 0);
        if (armed) begin
            chk("occ_a", 64'(occ_a), 64'(exp_occ));
            chk("occ_b", 64'(occ_b), 64'(exp_occ));
            chk("mem_ready_a", 64'(mem_ready_a), 64'(exp_occ < 2));
            chk("mem_ready_b", 64'(mem_ready_b), 64'(exp_occ < 2));
            chk("wb_valid_a", 64'(wb_valid_a), 64'(exp_occ > 0));
            chk("wb_valid_b", 64'(wb_valid_b), 64'(exp_occ > 0));
            if (exp_occ > 0) begin
                h = exp_q[0];
                chk("wd_a", 64'(wb_wd_a), 64'(h.wd_a));
                chk("wdata_a", 64'(wb_wdata_a), 64'(h.wdata_a));
                chk("hi_a", 64'(wb_hi_a), 64'(h.hi_a));
                chk("lo_a", 64'(wb_lo_a), 64'(h.lo_a));
                chk("wreg_a", 64'(wb_wreg_a), 64'(h.wreg));
                chk("whilo_a", 64'(wb_whilo_a), 64'(h.whilo));
                chk("wd_b", 64'(wb_wd_b), 64'(h.wd_b));
                chk("wdata_b", wb_wdata_b, h.wdata_b);
                chk("hi_b", wb_hi_b, h.hi_b);
                chk("lo_b", wb_lo_b, h.lo_b);
                chk("wreg_b", 64'(wb_wreg_b), 64'(h.wreg));
                chk("whilo_b", 64'(wb_whilo_b), 64'(h.whilo));
            end else begin
                chk("idle_wreg_a", 64'(wb_wreg_a), 64'd0);
                chk("idle_whilo_a", 64'(wb_whilo_a), 64'd0);
                chk("idle_wreg_b", 64'(wb_wreg_b), 64'd0);
                chk("idle_whilo_b", 64'(wb_whilo_b), 64'd0);
            end
            if (last_rst) begin
                chk("rst_wd_a", 64'(wb_wd_a), 64'd0);
                chk("rst_wdata_a", 64'(wb_wdata_a), 64'd0);
                chk("rst_hilo_a", 64'({wb_hi_a, wb_lo_a}), 64'd0);
                chk("rst_wd_b", 64'(wb_wd_b), 64'd0);
                chk("rst_wdata_b", wb_wdata_b, 64'd0);
                chk("rst_hilo_b", wb_hi_b | wb_lo_b, 64'd0);
            end
        end
        pushed_now = 1'b0;
        if (rst || flush) begin
            exp_q.delete();
        end else if (wb_ready && exp_occ > 0) begin
            void'(exp_q.pop_front());
        end
        last_rst = rst;
        if (rst) armed = 1'b1;
    end

    initial begin
        ent_t idle;
        idle = '0;
        // Reset for two cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0, idle);
        step(1'b1, 1'b0, 1'b0, 1'b0, idle);
        // Streaming at full rate.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, mk(5'(3 + i), 1'b1, 32'(32'h11 * (i + 1)), 1'b0, 32'h0, 32'h0));
        step(1'b0, 1'b0, 1'b0, 1'b1, idle);
        step(1'b0, 1'b0, 1'b0, 1'b1, idle);
        // Backpressure: A and B fill the buffer, C is held off until WB drains.
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(5'd1, 1'b1, 32'hA, 1'b0, 32'h0, 32'h0));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(5'd2, 1'b1, 32'hB, 1'b0, 32'h0, 32'h0));
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, mk(5'd9, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0));
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(5'd9, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0));
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(5'd9, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, idle);
        // Flush while full, with a same-cycle offer that must be dropped.
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(5'd10, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(5'd11, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0));
        step(1'b0, 1'b1, 1'b1, 1'b1, mk(5'd12, 1'b1, 32'h300, 1'b0, 32'h0, 32'h0));
        step(1'b0, 1'b0, 1'b0, 1'b0, idle);
        step(1'b0, 1'b0, 1'b0, 1'b1, idle);
        // HI/LO write with wreg=0: whilo visible for exactly the one valid cycle.
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(5'd7, 1'b0, 32'h55, 1'b1, 32'hDEAD, 32'hBEEF));
        step(1'b0, 1'b0, 1'b0, 1'b1, idle);
        step(1'b0, 1'b0, 1'b0, 1'b1, idle);
        // Reset while full, competing with flush, accept and pop.
        step(1'b0, 1'b0, 1'b1, 1'b0, rand_ent());
        step(1'b0, 1'b0, 1'b1, 1'b0, rand_ent());
        step(1'b1, 1'b1, 1'b1, 1'b1, rand_ent());
        step(1'b0, 1'b0, 1'b0, 1'b0, idle);
        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), rand_ent());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, idle);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of the write-back data, HI and LO fields.
REQ-002 SHALL provide parameter REG_AW, default 5, width of the destination register address.
REQ-003 SHALL provide ports, in this order:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  reset: synchronous, active-high, compared against `RstEnable.
- flush  in  1  discard all buffered entries.
- mem_valid  in  1  MEM presents an entry.
- mem_ready  out  1  pipe can accept an entry.
- mem_wd  in  REG_AW  destination register address.
- mem_wreg  in  1  GPR write enable.
- mem_wdata  in  DATA_W  GPR write data.
- mem_whilo  in  1  HI/LO write enable.
- mem_hi  in  DATA_W  HI write data.
- mem_lo  in  DATA_W  LO write data.
- wb_valid  out  1  WB entry valid.
- wb_ready  in  1  WB consumes the entry.
- wb_wd  out  REG_AW  destination register address.
- wb_wreg  out  1  GPR write enable, gated by wb_valid.
- wb_wdata  out  DATA_W  GPR write data.
- wb_whilo  out  1  HI/LO write enable, gated by wb_valid.
- wb_hi  out  DATA_W  HI data.
- wb_lo  out  DATA_W  LO data.
- occ  out  2  buffered entry count, 0..2.

Function
REQ-004 SHALL hold entries in a 2-entry in-order buffer made of a main register and a skid register; state SHALL be EMPTY, ONE or TWO.
REQ-005 SHALL accept an entry when mem_valid and mem_ready are both 1; SHALL pop the head entry when wb_valid and wb_ready are both 1.
REQ-006 SHALL drive mem_ready to 1 exactly when state is not TWO; mem_ready SHALL be decoded from the state register only, with no combinational path from wb_ready.
REQ-007 SHALL drive wb_valid to 1 exactly when state is ONE or TWO; the wb_* fields SHALL always show the head (main) entry.
REQ-008 SHALL show an accepted entry on wb_* with wb_valid=1 on the cycle after acceptance (1-cycle latency); SHALL sustain 1 entry/cycle while wb_ready stays 1.
REQ-009 Transitions:
- EMPTY, accept -> ONE.
- ONE, accept and no pop -> TWO; the new entry goes to skid.
- ONE, pop and no accept -> EMPTY.
- ONE, accept and pop -> ONE; main is reloaded with the new entry.
- TWO, pop -> ONE; skid moves into main.
- Any other case -> hold.
REQ-010 SHALL drive wb_wreg = main.wreg AND wb_valid, and wb_whilo = main.whilo AND wb_valid; register file and HI/LO writes SHALL never occur from an invalid slot.
REQ-011 SHALL treat an entry with wreg=0 and whilo=0 as a normal entry (a bubble); it SHALL occupy a slot and keep program order.
REQ-012 On flush=1 SHALL go to EMPTY at the next edge and discard both entries; flush SHALL take priority over a same-cycle accept or pop; data fields MAY keep stale values.
REQ-013 SHALL drive occ as 0/1/2 for EMPTY/ONE/TWO.
REQ-014 SHALL not modify, add to or truncate any data field; widths SHALL follow DATA_W and REG_AW exactly.

Reset
REQ-015 With rst at `RstEnable on an edge, SHALL enter EMPTY, giving mem_ready=1, wb_valid=0 and occ=0.
REQ-016 Under reset SHALL load both slots with wd=`NOPRegAddr, wreg=`WriteDisable, whilo=`WriteDisable, and wdata/hi/lo=`ZeroWord (zero-extended to DATA_W).
REQ-017 Reset SHALL take priority over flush, accept and pop, including when asserted mid-transfer in state TWO.

Structure
REQ-018 `RstEnable, `WriteDisable, `NOPRegAddr and `ZeroWord SHALL come from the shared defines file; the state encodings (EMPTY/ONE/TWO) SHALL be added there too.
REQ-019 The per-entry payload {wd, wreg, wdata, whilo, hi, lo} SHALL be handled as one packed vector of width REG_AW+2+3*DATA_W.
REQ-020 One sub-module is natural: pipe_skid, a generic 2-entry valid/ready skid buffer with parameter W; mem_wb_pipe SHALL add only write-enable gating, packing and occ.

Verification
REQ-021 Reset check: assert rst for 2 cycles -> mem_ready=1, wb_valid=0, wb_wreg=0, wb_whilo=0, wb_wd=0, wb_wdata=0, occ=0.
REQ-022 Streaming: wb_ready=1; send wd=3/wdata=0x11, wd=4/0x22, wd=5/0x33 on consecutive cycles -> each entry on wb_* one cycle later, in order; mem_ready stays 1; occ stays 1.
REQ-023 Backpressure: wb_ready=0; send 0xA then 0xB -> occ=2 and mem_ready=0; a third entry 0xC is held off; raise wb_ready -> wb_wdata shows 0xA, then 0xB, then 0xC.
REQ-024 Flush priority: in state TWO, assert flush together with mem_valid=1 -> next cycle occ=0, wb_valid=0 and the offered entry is dropped.
REQ-025 HI/LO and gating: send whilo=1, hi=0xDEAD, lo=0xBEEF, wreg=0 -> wb_whilo=1 for exactly the one valid cycle; wb_wreg=0 throughout; after the pop wb_whilo=0.
REQ-026 Parametrisation: rerun REQ-022 with DATA_W=64, REG_AW=6 -> values pass through with all bits intact.
